iobus_sseg_ctrl: RTL and testbench



---
 rtl/otter_io_pkg.sv | 22 ++
 rtl/hex_to_sseg.sv | 15 +
 rtl/iobus_sseg_ctrl.sv | 137 +++++++++++++
 tb/tb_iobus_sseg_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
`timescale 1ns/1ps
// otter_io_pkg
// Shared constants for OTTER IOBUS peripherals: register offsets of the
// seven-segment controller, the blank cathode pattern, and the active-low
// hex-to-segment lookup table (gfedcba, bit 6 = g).
package otter_io_pkg;

  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] CTRL_OFS   = 32'h4;
  localparam logic [31:0] STATUS_OFS = 32'h8;

  localparam logic [7:0]  SSEG_BLANK = 8'hFF;

  // Entry 15 first so HEX_SSEG_TBL[n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SSEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_sseg.sv
`timescale 1ns/1ps
// hex_to_sseg
// Combinational 4-bit hex to 7-segment decoder, active-low cathodes.
//   hex [3:0] in  : nibble to display
//   seg [6:0] out : gfedcba, 0 = segment lit
module hex_to_sseg
  import otter_io_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SSEG_TBL[hex];

endmodule

// File: rtl/iobus_sseg_ctrl.sv
`timescale 1ns/1ps
// iobus_sseg_ctrl
// Four-digit multiplexed seven-segment display controller on the OTTER IOBUS.
// Registers (word addresses relative to BASE_ADDR):
//   +0 DATA   R/W : [15:0] shadow value, write sets pending
//   +4 CTRL   R/W : [0] enable, [7:4] dp mask (1 = lit)
//   +8 STATUS RO  : [1:0] digit index, [2] pending
// The shadow value is transferred to the displayed value only at a frame
// boundary (digit index wrapping 3->0), so a frame never shows a torn value.
// Ports:
//   CLK, RST         : clock, synchronous active-high reset
//   IOBUS_ADDR/OUT/WR: MCU bus address, write data, write strobe
//   IOBUS_IN         : combinational read data, 0 when not addressed
//   SEGS [7:0]       : active-low cathodes, [7] = dp, [6:0] = gfedcba
//   AN   [3:0]       : active-low anodes, AN[0] = rightmost digit
// Build option: define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero
// digits 3..1 (digit 0 always shown).
module iobus_sseg_ctrl
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1100C010,
  parameter int          REFRESH_DIV = 50000
)(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic [7:0]  SEGS,
  output logic [3:0]  AN
);

  localparam int NUM_DIGITS = 4;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [15:0]   shadow, active;
  logic [7:0]    ctrl;
  logic          pending;
  logic [PW-1:0] presc;
  logic [1:0]    digit;

  logic sel_data, sel_ctrl, sel_status;
  logic wr_data, wr_ctrl;
  logic tc, wrap;

  assign sel_data   = (IOBUS_ADDR == BASE_ADDR + DATA_OFS);
  assign sel_ctrl   = (IOBUS_ADDR == BASE_ADDR + CTRL_OFS);
  assign sel_status = (IOBUS_ADDR == BASE_ADDR + STATUS_OFS);
  assign wr_data    = IOBUS_WR & sel_data;
  assign wr_ctrl    = IOBUS_WR & sel_ctrl;

  assign tc   = (presc == PRESC_MAX);
  assign wrap = tc & (digit == 2'd3);

  // Only the low half of the write word carries register bits.
  logic unused_wdata;
  assign unused_wdata = ^IOBUS_OUT[31:16];

  // Register file and scan counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow  <= '0;
      active  <= '0;
      ctrl    <= '0;
      pending <= 1'b0;
      presc   <= '0;
      digit   <= '0;
    end else begin
      if (wr_data) shadow <= IOBUS_OUT[15:0];
      if (wr_ctrl) ctrl   <= {IOBUS_OUT[7:4], 3'b000, IOBUS_OUT[0]};
      presc <= tc ? '0 : presc + 1'b1;
      if (tc)   digit  <= digit + 2'd1;
      // active samples the pre-write shadow; a coincident write keeps
      // pending set so the new value lands on the following frame.
      if (wrap) active <= shadow;
      if (wr_data)   pending <= 1'b1;
      else if (wrap) pending <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    IOBUS_IN = '0;
    if (sel_data)   IOBUS_IN = {16'h0, shadow};
    if (sel_ctrl)   IOBUS_IN = {24'h0, ctrl};
    if (sel_status) IOBUS_IN = {29'h0, pending, digit};
  end

  // Per-digit decode, all digits in parallel, then select the scanned one.
  logic [NUM_DIGITS-1:0][6:0] hex_seg;
  logic [NUM_DIGITS-1:0]      blank;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex_to_sseg u_dec (
      .hex (active[4*g +: 4]),
      .seg (hex_seg[g])
    );
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if (g == 0) begin : g_b0
      assign blank[g] = 1'b0;
    end else begin : g_bn
      assign blank[g] = ((active >> (4*g)) == 16'h0);
    end
`else
    assign blank[g] = 1'b0;
`endif
  end

  logic [3:0] dp_mask;
  logic [7:0] segs_nxt;
  logic [3:0] an_nxt;

  assign dp_mask = ctrl[7:4];

  always_comb begin
    segs_nxt = SSEG_BLANK;
    an_nxt   = 4'hF;
    if (ctrl[0] && !blank[digit]) begin
      segs_nxt = {~dp_mask[digit], hex_seg[digit]};
      an_nxt   = ~(4'b0001 << digit);
    end
  end

  // Pin registers: follow the scan state one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEGS <= SSEG_BLANK;
      AN   <= 4'hF;
    end else begin
      SEGS <= segs_nxt;
      AN   <= an_nxt;
    end
  end

endmodule

// File: tb/tb_iobus_sseg_ctrl.sv
`timescale 1ns/1ps
module tb_iobus_sseg_ctrl;

  localparam logic [31:0] BASE = 32'h1100C010;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  segs;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  iobus_sseg_ctrl #(.BASE_ADDR(BASE), .REFRESH_DIV(4)) dut (
    .CLK(clk), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata),
    .IOBUS_WR(wr), .IOBUS_IN(rdata), .SEGS(segs), .AN(an)
  );

  always #5 clk = ~clk;

  // Counts non-reset edges since reset release.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int k);
    if (cyc > k) chk("goto_overrun", cyc, k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wreg(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic pins(input string tag, input logic [3:0] ea, input logic [7:0] es);
    chk({tag, "_an"}, {28'h0, an}, {28'h0, ea});
    chk({tag, "_segs"}, {24'h0, segs}, {24'h0, es});
  endtask

  initial begin
    // Reset
    @(negedge clk); @(negedge clk);
    pins("rst", 4'hF, 8'hFF);
    rd("rst_data", BASE, 32'h0);
    rd("rst_ctrl", BASE + 4, 32'h0);
    rd("rst_stat", BASE + 8, 32'h0);
    rst = 1'b0;

    // Display
    wreg(BASE + 4, 32'h1);               // edge 1
    pins("ctrl_lat1", 4'hF, 8'hFF);      // cyc 1: not yet visible
    wreg(BASE, 32'h1234);                // edge 2
    pins("ctrl_lat2", 4'hE, 8'hC0);      // cyc 2: ctrl visible
    rd("ctrl_rb", BASE + 4, 32'h1);
    rd("stat_pend", BASE + 8, 32'h4);
    goto(16);
    pins("pre_frame", BLANK ? 4'hF : 4'h7, BLANK ? 8'hFF : 8'hC0);
    rd("stat_f1", BASE + 8, 32'h0);
    goto(17); pins("d0_4", 4'hE, 8'h99);
    goto(21); pins("d1_3", 4'hD, 8'hB0);
    goto(25); pins("d2_2", 4'hB, 8'hA4);
    goto(29); pins("d3_1", 4'h7, 8'hF9);

    // Readback and pending
    wreg(BASE, 32'hFFFF_BEEF);           // edge 30
    rd("beef_rb", BASE, 32'h0000BEEF);
    rd("beef_pend", BASE + 8, 32'h7);
    goto(31); rd("beef_pend2", BASE + 8, 32'h7);
    goto(32); rd("beef_clr", BASE + 8, 32'h0);
    goto(33); pins("beef_d0", 4'hE, 8'h8E);

    // Write on the wrap cycle (edge 48)
    goto(47);
    wreg(BASE, 32'h5678);
    rd("wb_pend", BASE + 8, 32'h4);
    goto(49); pins("wb_old_d0", 4'hE, 8'h8E);
    goto(61); pins("wb_old_d3", 4'h7, 8'h83);
    goto(63); rd("wb_pend_end", BASE + 8, 32'h7);
    goto(64); rd("wb_clr", BASE + 8, 32'h0);
    goto(65); pins("wb_new_d0", 4'hE, 8'h80);
    goto(69); pins("wb_new_d1", 4'hD, 8'hF8);

    // Leading-zero blanking
    wreg(BASE + 4, 32'h11);              // edge 70
    wreg(BASE, 32'h0005);                // edge 71
    rd("lz_ctrl", BASE + 4, 32'h11);
    rd("lz_stat", BASE + 8, 32'h5);
    goto(81); pins("lz_d0", 4'hE, 8'h12);
    goto(85); pins("lz_d1", BLANK ? 4'hF : 4'hD, BLANK ? 8'hFF : 8'hC0);
    goto(89); pins("lz_d2", BLANK ? 4'hF : 4'hB, BLANK ? 8'hFF : 8'hC0);
    goto(93); pins("lz_d3", BLANK ? 4'hF : 4'h7, BLANK ? 8'hFF : 8'hC0);

    // Ignored writes, CTRL reserved bits, disable
    wreg(BASE + 8, 32'hFFFF_FFFF);       // edge 94
    wreg(BASE + 12, 32'hFFFF_FFFF);      // edge 95
    rd("ofsc_rd", BASE + 12, 32'h0);
    rd("data_kept", BASE, 32'h5);
    rd("stat_ro", BASE + 8, 32'h3);
    wreg(BASE + 4, 32'hFFFF_FF3E);       // edge 96
    rd("ctrl_mask", BASE + 4, 32'h30);
    goto(97); pins("disabled", 4'hF, 8'hFF);

    // Mid-operation reset during digit 2 with pending set
    wreg(BASE + 4, 32'h1);               // edge 98
    wreg(BASE, 32'h9ABC);                // edge 99
    goto(105);
    rd("pre_rst_stat", BASE + 8, 32'h6);
    rst = 1'b1;
    @(negedge clk);
    pins("midrst", 4'hF, 8'hFF);
    rd("midrst_data", BASE, 32'h0);
    rd("midrst_ctrl", BASE + 4, 32'h0);
    rd("midrst_stat", BASE + 8, 32'h0);
    rst = 1'b0;
    wreg(BASE + 4, 32'h1);               // edge 1
    goto(17); pins("post_rst", 4'hE, 8'hC0);
    rd("post_rst_data", BASE, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
